glitch_filter: RTL and testbench
================================

GLITCH_FILTER -- requirements
Module: glitch_filter

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive synchronized samples a new level must hold before it is accepted; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: width of the glitch event counter.
REQ-003 clk  input  1  single clock, rising-edge; all state on this clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 a_in  input  1  raw, asynchronous, possibly glitchy level.
REQ-006 clr_cnt  input  1  synchronous clear of glitch_cnt, sampled high on a clk edge.
REQ-007 y  output  1  filtered, registered level.
REQ-008 rise  output  1  one-cycle pulse, registered, when y goes 0->1.
REQ-009 fall  output  1  one-cycle pulse, registered, when y goes 1->0.
REQ-010 glitch  output  1  one-cycle pulse, registered, when a pending transition is aborted.
REQ-011 glitch_cnt  output  CNT_W  saturating count of glitch events.

Function
REQ-012 a_in SHALL pass through a two-flop synchronizer; its second stage is the sample s.
REQ-013 The FSM SHALL have two states: STABLE and PENDING, plus a run counter cnt of 8 bits.
REQ-014 STABLE, s==y: remain STABLE, cnt=0.
REQ-015 STABLE, s!=y: go PENDING, cnt<=1.
REQ-016 PENDING, s==y: go STABLE, cnt<=0, glitch<=1 for one cycle, y unchanged.
REQ-017 PENDING, s!=y, cnt==STABLE_CYCLES-1: y<=s, rise or fall<=1 for one cycle, go STABLE, cnt<=0.
REQ-018 PENDING, s!=y, cnt<STABLE_CYCLES-1: cnt<=cnt+1.
REQ-019 Latency: a_in change held stable updates y at the (2+STABLE_CYCLES)-th rising edge after the change, counting from the first edge at which the change meets setup.
REQ-020 rise, fall and glitch SHALL be mutually exclusive in any cycle and SHALL never be high for two consecutive cycles from the same event.
REQ-021 glitch_cnt SHALL increment by 1 on each glitch pulse and saturate at 2^CNT_W-1 without wrap.
REQ-022 clr_cnt high SHALL load glitch_cnt with 0; when it coincides with a glitch event, clear wins and that event is not counted; the glitch pulse itself is still emitted.
REQ-023 Pulses shorter than one clock that are missed by the synchronizer SHALL produce no output activity.

Reset
REQ-024 rst_n low SHALL immediately force: sync flops 0, y 0, rise 0, fall 0, glitch 0, state STABLE, cnt 0, glitch_cnt 0.
REQ-025 Reset asserted during PENDING SHALL abort the transition with no rise, fall or glitch pulse.
REQ-026 After rst_n deasserts with a_in high, y SHALL rise per REQ-019 and emit one rise pulse.

Configuration
REQ-027 Macro GLITCH_FILTER_CNT_EN defined: glitch_cnt and clr_cnt logic is implemented per REQ-021/022.
REQ-028 GLITCH_FILTER_CNT_EN undefined: glitch_cnt SHALL be tied to 0, clr_cnt is ignored, and no counter flops are present; all other behaviour is identical.

Structure
REQ-029 Package glitch_pkg SHALL hold the FSM state typedef (STABLE, PENDING) and the default constants for STABLE_CYCLES and CNT_W.
REQ-030 The two-flop synchronizer SHALL be a separate sub-module glitch_sync with inputs clk, rst_n, d and output q, reset value 0.
REQ-031 Elaboration SHALL fail when STABLE_CYCLES is outside 2..255.

Verification (10 ns clock, defaults, GLITCH_FILTER_CNT_EN defined)
REQ-032 Reset, a_in=0 for 100 ns -> y=0, no pulses, glitch_cnt=0.
REQ-033 a_in 0->1 held -> y=1 at the 6th edge after the change, and rise is high for exactly that cycle.
REQ-034 a_in high for 10 ns, then low for 10 ns, repeated twice -> y stays 0, two glitch pulses, glitch_cnt=2.
REQ-035 clr_cnt pulses on the same edge as a glitch pulse -> glitch_cnt=0 afterwards; force 300 glitches with CNT_W=8 -> glitch_cnt=255.
REQ-036 rst_n pulled low 3 cycles into PENDING -> y=0, no rise, fall or glitch pulse; with the macro undefined, REQ-034 stimulus -> glitch_cnt=0 and glitch pulses unchanged.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared types and default constants for the glitch filter.
//   state_t            : filter FSM state (STABLE, PENDING)
//   STABLE_CYCLES_DEF  : default number of matching samples needed to accept a level
//   CNT_W_DEF          : default width of the glitch event counter
//   RUN_W              : width of the internal run counter
package glitch_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam int STABLE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 8;
    localparam int RUN_W             = 8;

endpackage

// File: rtl/glitch_sync.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, both stages reset to 0
//   d     : asynchronous input level
//   q     : synchronized level (second stage)
module glitch_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/glitch_filter.sv
// Debounce / glitch filter for an asynchronous level.
// A new level is accepted only after STABLE_CYCLES consecutive synchronized
// samples; shorter excursions are reported as glitches and counted.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   a_in       : raw asynchronous input level
//   clr_cnt    : synchronous clear of glitch_cnt (wins over a same-edge glitch)
//   y          : filtered level (registered)
//   rise, fall : one-cycle pulses when y goes 0->1 / 1->0
//   glitch     : one-cycle pulse when a pending transition is aborted
//   glitch_cnt : saturating glitch counter
//
// Build option: define GLITCH_FILTER_CNT_EN to implement glitch_cnt/clr_cnt;
// otherwise glitch_cnt is tied to 0 and clr_cnt is ignored.
module glitch_filter
    import glitch_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             clr_cnt,
    output logic             y,
    output logic             rise,
    output logic             fall,
    output logic             glitch,
    output logic [CNT_W-1:0] glitch_cnt
);

    generate
        if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
            $error("glitch_filter: STABLE_CYCLES must be in 2..255");
        end
    endgenerate

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);

    logic             s;
    state_t           state_q;
    logic [RUN_W-1:0] cnt_q;
    logic             y_q;
    logic             rise_q;
    logic             fall_q;
    logic             glitch_q;
    logic             abort;

    glitch_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (a_in),
        .q     (s)
    );

    // A pending transition is aborted when the sample falls back to the current level.
    assign abort = (state_q == PENDING) && (s == y_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            y_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
            case (state_q)
                STABLE: begin
                    if (s != y_q) begin
                        state_q <= PENDING;
                        cnt_q   <= RUN_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                PENDING: begin
                    if (abort) begin
                        state_q  <= STABLE;
                        cnt_q    <= '0;
                        glitch_q <= 1'b1;
                    end else if (cnt_q == RUN_LAST) begin
                        // This sample completes the run: accept the new level.
                        y_q     <= s;
                        rise_q  <= s;
                        fall_q  <= ~s;
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + RUN_W'(1);
                    end
                end
                default: begin
                    state_q <= STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef GLITCH_FILTER_CNT_EN
    logic [CNT_W-1:0] glitch_cnt_q;
    logic [CNT_W-1:0] glitch_cnt_d;

    // Counts on the same edge that raises the glitch pulse, so a clear
    // sampled on that edge suppresses the count.
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (clr_cnt) begin
            glitch_cnt_d = '0;
        end else if (abort && (glitch_cnt_q != {CNT_W{1'b1}})) begin
            glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign glitch_cnt     = '0;
`endif

    assign y      = y_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign glitch = glitch_q;

endmodule

// File: tb/tb_glitch_filter.sv
// Self-checking bench for glitch_filter with a run-length reference model.
module tb_glitch_filter;

    localparam int SC    = 4;
    localparam int CNT_W = 8;
`ifdef GLITCH_FILTER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             a_in;
    logic             clr_cnt;
    logic             y;
    logic             rise;
    logic             fall;
    logic             glitch;
    logic [CNT_W-1:0] glitch_cnt;

    int errors = 0;
    int checks = 0;

    glitch_filter #(
        .STABLE_CYCLES (SC),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_in       (a_in),
        .clr_cnt    (clr_cnt),
        .y          (y),
        .rise       (rise),
        .fall       (fall),
        .glitch     (glitch),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: y flips once SC consecutive synchronized samples differ
    // from it; any shorter non-empty run of differing samples is a glitch.
    logic m_s1, m_s2, m_s, m_y, m_rise, m_fall, m_glitch;
    int   m_run, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_y = 0; m_rise = 0; m_fall = 0; m_glitch = 0;
            m_run = 0; m_cnt = 0;
        end else begin
            m_s = m_s2;
            m_rise = 0; m_fall = 0; m_glitch = 0;
            if (m_s != m_y) begin
                m_run = m_run + 1;
                if (m_run == SC) begin
                    m_y = m_s;
                    if (m_s) m_rise = 1; else m_fall = 1;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0) m_glitch = 1;
                m_run = 0;
            end
            if (CNT_EN) begin
                if (clr_cnt) m_cnt = 0;
                else if (m_glitch && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
            m_s2 = m_s1;
            m_s1 = a_in;
        end
    end

    // Continuous scoreboard and pulse bookkeeping, sampled on the falling edge.
    int  n_rise = 0, n_fall = 0, n_glitch = 0;
    logic p_rise = 0, p_fall = 0, p_glitch = 0;

    always @(negedge clk) begin
        checks = checks + 1;
        if ({y, rise, fall, glitch} !== {m_y, m_rise, m_fall, m_glitch}) begin
            errors = errors + 1;
            $display("FAIL model_outputs t=%0t y/rise/fall/glitch got %b%b%b%b want %b%b%b%b",
                     $time, y, rise, fall, glitch, m_y, m_rise, m_fall, m_glitch);
        end
        checks = checks + 1;
        if (glitch_cnt !== CNT_W'(m_cnt)) begin
            errors = errors + 1;
            $display("FAIL model_glitch_cnt t=%0t got %0d want %0d", $time, glitch_cnt, m_cnt);
        end
        checks = checks + 1;
        if ((32'(rise) + 32'(fall) + 32'(glitch)) > 1 ||
            (rise && p_rise) || (fall && p_fall) || (glitch && p_glitch)) begin
            errors = errors + 1;
            $display("FAIL pulse_exclusive t=%0t got rise=%b fall=%b glitch=%b prev=%b%b%b want single non-repeated pulse",
                     $time, rise, fall, glitch, p_rise, p_fall, p_glitch);
        end
        if (rise === 1'b1) n_rise = n_rise + 1;
        if (fall === 1'b1) n_fall = n_fall + 1;
        if (glitch === 1'b1) n_glitch = n_glitch + 1;
        p_rise = rise; p_fall = fall; p_glitch = glitch;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; a_in = 0; clr_cnt = 0;
        idle(10);
        checks = checks + 1;
        if ({y, rise, fall, glitch} !== 4'b0000 || glitch_cnt !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_state got y/r/f/g=%b%b%b%b cnt=%0d want 0000 cnt=0",
                     y, rise, fall, glitch, glitch_cnt);
        end
        rst_n = 1;
        idle(10);
        checks = checks + 1;
        if (y !== 1'b0 || n_rise + n_fall + n_glitch != 0 || glitch_cnt !== '0) begin
            errors = errors + 1;
            $display("FAIL idle_low got y=%b pulses=%0d cnt=%0d want 0 0 0",
                     y, n_rise + n_fall + n_glitch, glitch_cnt);
        end
    endtask

    task automatic test_edge_latency(input logic lvl);
        int r0, f0;
        r0 = n_rise; f0 = n_fall;
        a_in = lvl;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            checks = checks + 1;
            if (y !== ((i >= 2 + SC) ? lvl : ~lvl)) begin
                errors = errors + 1;
                $display("FAIL latency_y lvl=%b edge=%0d got %b want %b", lvl, i, y,
                         (i >= 2 + SC) ? lvl : ~lvl);
            end
            checks = checks + 1;
            if ((lvl ? rise : fall) !== (i == 2 + SC)) begin
                errors = errors + 1;
                $display("FAIL latency_pulse lvl=%b edge=%0d got %b want %b", lvl, i,
                         lvl ? rise : fall, i == 2 + SC);
            end
        end
        @(negedge clk);
        checks = checks + 1;
        if ((n_rise - r0) != (lvl ? 1 : 0) || (n_fall - f0) != (lvl ? 0 : 1)) begin
            errors = errors + 1;
            $display("FAIL edge_pulse_count lvl=%b got rise=%0d fall=%0d want exactly one",
                     lvl, n_rise - r0, n_fall - f0);
        end
    endtask

    task automatic test_glitch();
        int g0;
        clr_cnt = 1; @(negedge clk); clr_cnt = 0;
        idle(3);
        g0 = n_glitch;
        for (int k = 0; k < 2; k++) begin
            a_in = 1; @(negedge clk);
            a_in = 0; @(negedge clk);
        end
        idle(8);
        checks = checks + 1;
        if (y !== 1'b0 || (n_glitch - g0) != 2) begin
            errors = errors + 1;
            $display("FAIL glitch_pair got y=%b glitches=%0d want y=0 glitches=2", y, n_glitch - g0);
        end
        checks = checks + 1;
        if (glitch_cnt !== CNT_W'(CNT_EN ? 2 : 0)) begin
            errors = errors + 1;
            $display("FAIL glitch_pair_cnt got %0d want %0d", glitch_cnt, CNT_EN ? 2 : 0);
        end
    endtask

    task automatic test_clr_collision();
        a_in = 1; @(negedge clk);
        a_in = 0; @(negedge clk);
        @(negedge clk);
        clr_cnt = 1;
        @(posedge clk); #1;
        checks = checks + 1;
        if (glitch !== 1'b1 || glitch_cnt !== '0) begin
            errors = errors + 1;
            $display("FAIL clr_collision got glitch=%b cnt=%0d want glitch=1 cnt=0", glitch, glitch_cnt);
        end
        @(negedge clk); clr_cnt = 0;
        idle(4);
        checks = checks + 1;
        if (glitch_cnt !== '0) begin
            errors = errors + 1;
            $display("FAIL clr_after got %0d want 0", glitch_cnt);
        end
    endtask

    task automatic test_short_pulse();
        int act0;
        act0 = n_rise + n_fall + n_glitch;
        for (int k = 0; k < 3; k++) begin
            #2 a_in = 1;
            #2 a_in = 0;
            @(negedge clk);
        end
        idle(10);
        checks = checks + 1;
        if (y !== 1'b0 || (n_rise + n_fall + n_glitch) != act0) begin
            errors = errors + 1;
            $display("FAIL short_pulse got y=%b activity=%0d want y=0 activity=0",
                     y, n_rise + n_fall + n_glitch - act0);
        end
    endtask

    task automatic test_saturation();
        int g0;
        g0 = n_glitch;
        for (int k = 0; k < 300; k++) begin
            a_in = 1; @(negedge clk);
            a_in = 0; idle(3);
        end
        idle(5);
        checks = checks + 1;
        if ((n_glitch - g0) != 300) begin
            errors = errors + 1;
            $display("FAIL sat_glitches got %0d want 300", n_glitch - g0);
        end
        checks = checks + 1;
        if (glitch_cnt !== CNT_W'(CNT_EN ? CNT_MAX : 0)) begin
            errors = errors + 1;
            $display("FAIL sat_cnt got %0d want %0d", glitch_cnt, CNT_EN ? CNT_MAX : 0);
        end
    endtask

    task automatic test_reset_pending();
        int act0;
        act0 = n_rise + n_fall + n_glitch;
        a_in = 1;
        idle(5);
        rst_n = 0; a_in = 0;
        #1;
        checks = checks + 1;
        if ({y, rise, fall, glitch} !== 4'b0000 || glitch_cnt !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_async got y/r/f/g=%b%b%b%b cnt=%0d want 0000 cnt=0",
                     y, rise, fall, glitch, glitch_cnt);
        end
        idle(3);
        rst_n = 1;
        idle(10);
        checks = checks + 1;
        if (y !== 1'b0 || (n_rise + n_fall + n_glitch) != act0) begin
            errors = errors + 1;
            $display("FAIL reset_pending got y=%b activity=%0d want y=0 activity=0",
                     y, n_rise + n_fall + n_glitch - act0);
        end
    endtask

    task automatic test_reset_release_high();
        int r0;
        rst_n = 0; a_in = 1;
        idle(2);
        r0 = n_rise;
        rst_n = 1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            checks = checks + 1;
            if (y !== (i >= 2 + SC) || rise !== (i == 2 + SC)) begin
                errors = errors + 1;
                $display("FAIL release_high edge=%0d got y=%b rise=%b want y=%b rise=%b",
                         i, y, rise, i >= 2 + SC, i == 2 + SC);
            end
        end
        @(negedge clk);
        checks = checks + 1;
        if ((n_rise - r0) != 1) begin
            errors = errors + 1;
            $display("FAIL release_high_rises got %0d want 1", n_rise - r0);
        end
    endtask

    task automatic test_random();
        int len;
        for (int k = 0; k < 200; k++) begin
            a_in = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 2 * SC);
            for (int j = 0; j < len; j++) begin
                clr_cnt = ($urandom_range(0, 19) == 0);
                @(negedge clk);
            end
        end
        clr_cnt = 0;
        idle(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_edge_latency(1'b1);
        test_edge_latency(1'b0);
        test_glitch();
        test_clr_collision();
        test_short_pulse();
        test_saturation();
        test_reset_pending();
        test_reset_release_high();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
